// File: rtl/ram_access_ctrl.sv
// Round-robin arbiter/sequencer sharing a single-port registered-read RAM
// between an instruction-fetch port (I) and a load/store port (D).
module ram_access_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic          i_err,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_done,
  output logic          d_err,
  output logic [31:0]   d_rdata,
  output logic          read_ram,
  output logic          write_ram,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_write_data,
  input  logic [31:0]   ram_out,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;
  logic          read_ram_q, read_ram_d;
  logic          write_ram_q, write_ram_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;

  logic          i_elig, d_elig, grant_en, gnt_is_d;
  logic          sel_we, sel_oor;
  logic [AW-1:0] sel_addr;

  // During RESP the current owner is excluded so the other port gets the next slot.
  assign i_elig   = i_req && !(state_q == RESP && owner_q == PORT_I);
  assign d_elig   = d_req && !(state_q == RESP && owner_q == PORT_D);
  assign grant_en = (state_q == IDLE || state_q == RESP) && (i_elig || d_elig);
  assign gnt_is_d = d_elig && (!i_elig || last_gnt_q == PORT_I);

  assign sel_addr = gnt_is_d ? d_addr : i_addr;
  assign sel_we   = gnt_is_d && d_we;
  assign sel_oor  = sel_addr >= AW'(DEPTH);

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    oor_d       = oor_q;
    read_ram_d  = 1'b0;
    write_ram_d = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;

    case (state_q)
      CMD:     state_d = RESP;
      IDLE,
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_en) begin
      state_d     = CMD;
      owner_d     = gnt_is_d;
      last_gnt_d  = gnt_is_d;
      we_d        = sel_we;
      oor_d       = sel_oor;
      // Out-of-range commands are suppressed entirely at the RAM.
      read_ram_d  = !sel_oor && !sel_we;
      write_ram_d = !sel_oor && sel_we;
      ram_addr_d  = sel_oor ? '0 : sel_addr;
      ram_wdata_d = (!sel_oor && sel_we) ? d_wdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= PORT_I;
      owner_q     <= PORT_I;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      read_ram_q  <= 1'b0;
      write_ram_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      read_ram_q  <= read_ram_d;
      write_ram_q <= write_ram_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign read_ram       = read_ram_q;
  assign write_ram      = write_ram_q;
  assign ram_addr       = ram_addr_q;
  assign ram_write_data = ram_wdata_q;
  assign busy           = state_q != IDLE;

  // RAM read data arrives during RESP, so response data is steered combinationally.
  assign i_done  = state_q == RESP && owner_q == PORT_I;
  assign i_err   = i_done && oor_q;
  assign i_rdata = (i_done && !oor_q) ? ram_out : 32'd0;
  assign d_done  = state_q == RESP && owner_q == PORT_D;
  assign d_err   = d_done && oor_q;
  assign d_rdata = (d_done && !oor_q && !we_q) ? ram_out : 32'd0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized self-checking bench for ram_access_ctrl with a transaction-level
// reference model (round-robin order, fixed latency, reference memory).
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_done, i_err, d_done, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        read_ram, write_ram, busy;
  logic [31:0] ram_addr, ram_write_data;
  logic [31:0] ram_out = '0;

  logic [31:0] mem [16] = '{default: 32'd0};
  logic [31:0] ref_mem [16];
  bit          model_last_d;
  int          n_vec = 0;
  int          n_err = 0;
  int          txn_no = 0;

  always #5 clk = ~clk;

  ram_access_ctrl #(.DEPTH(16), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .read_ram(read_ram), .write_ram(write_ram), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_out(ram_out), .busy(busy)
  );

  // Behavioural single-port RAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (write_ram && ram_addr < 32'd16) mem[ram_addr[3:0]] <= ram_write_data;
    if (read_ram && ram_addr < 32'd16) ram_out <= mem[ram_addr[3:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " i_done"}, i_done, 0);
    check_val({tag, " d_done"}, d_done, 0);
    check_val({tag, " i_err"}, i_err, 0);
    check_val({tag, " d_err"}, d_err, 0);
    check_val({tag, " i_rdata"}, i_rdata, 0);
    check_val({tag, " d_rdata"}, d_rdata, 0);
    check_val({tag, " read_ram"}, read_ram, 0);
    check_val({tag, " write_ram"}, write_ram, 0);
    check_val({tag, " ram_addr"}, ram_addr, 0);
    check_val({tag, " ram_wdata"}, ram_write_data, 0);
    check_val({tag, " busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    model_last_d = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue requests from IDLE and check 8 cycles against the transaction model.
  task automatic run_group(input bit ion, input bit don, input logic [31:0] ia,
                           input logic [31:0] da, input bit we, input logic [31:0] wd);
    bit first_d;
    int e_i, e_d, last_e;
    logic [31:0] exp_ir, exp_dr;
    bit i_in, d_in;
    logic x_rd, x_wr;
    logic [31:0] x_addr, x_wd;

    first_d = (ion && don) ? !model_last_d : don;
    e_i = -1; e_d = -1;
    if (ion) e_i = (don && first_d) ? 4 : 2;
    if (don) e_d = (ion && !first_d) ? 4 : 2;
    last_e = (e_i > e_d) ? e_i : e_d;
    if (ion && don) model_last_d = !first_d;
    else model_last_d = don;

    i_in = ia < 32'd16;
    d_in = da < 32'd16;
    exp_ir = 0; exp_dr = 0;
    if (first_d) begin
      if (don && d_in) begin if (we) ref_mem[da[3:0]] = wd; else exp_dr = ref_mem[da[3:0]]; end
      if (ion && i_in) exp_ir = ref_mem[ia[3:0]];
    end else begin
      if (ion && i_in) exp_ir = ref_mem[ia[3:0]];
      if (don && d_in) begin if (we) ref_mem[da[3:0]] = wd; else exp_dr = ref_mem[da[3:0]]; end
    end

    i_req = ion; i_addr = ia;
    d_req = don; d_addr = da; d_we = we; d_wdata = wd;
    $display("txn %0d: i_req=%0b i_addr=%0d d_req=%0b d_addr=%0d we=%0b wdata=%h i_done@%0d d_done@%0d",
             txn_no, ion, ia, don, da, we, wd, e_i, e_d);
    txn_no++;

    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      check_val("i_done", i_done, (cyc == e_i) ? 1 : 0);
      check_val("d_done", d_done, (cyc == e_d) ? 1 : 0);
      check_val("i_err", i_err, (cyc == e_i && !i_in) ? 1 : 0);
      check_val("d_err", d_err, (cyc == e_d && !d_in) ? 1 : 0);
      check_val("i_rdata", i_rdata, (cyc == e_i) ? exp_ir : 0);
      check_val("d_rdata", d_rdata, (cyc == e_d) ? exp_dr : 0);
      check_val("busy", busy, (cyc >= 1 && cyc <= last_e) ? 1 : 0);
      x_rd = 0; x_wr = 0; x_addr = 0; x_wd = 0;
      if (cyc == e_i - 1 && i_in) begin
        x_rd = 1; x_addr = ia;
      end else if (cyc == e_d - 1 && d_in) begin
        x_rd = !we; x_wr = we; x_addr = da; x_wd = we ? wd : 0;
      end
      check_val("read_ram", read_ram, x_rd);
      check_val("write_ram", write_ram, x_wr);
      check_val("ram_addr", ram_addr, x_addr);
      check_val("ram_wdata", ram_write_data, x_wd);
      @(posedge clk); #1;
      if (cyc == e_i) i_req = 0;
      if (cyc == e_d) d_req = 0;
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'd0;
    do_reset();

    // Store then load at address 5.
    run_group(0, 1, 0, 5, 1, 32'hDEADBEEF);
    run_group(0, 1, 0, 5, 0, 32'h0);
    run_group(0, 1, 0, 3, 1, 32'h1234_5678);
    run_group(0, 1, 0, 7, 1, 32'hCAFE_F00D);

    // Both ports contending from reset: order D, I, D, I.
    do_reset();
    i_req = 1; i_addr = 3; d_req = 1; d_addr = 7; d_we = 0; d_wdata = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      check_val("alt d_done", d_done, (cyc == 2 || cyc == 6) ? 1 : 0);
      check_val("alt i_done", i_done, (cyc == 4 || cyc == 8) ? 1 : 0);
      check_val("alt d_rdata", d_rdata, (cyc == 2 || cyc == 6) ? ref_mem[7] : 0);
      check_val("alt i_rdata", i_rdata, (cyc == 4 || cyc == 8) ? ref_mem[3] : 0);
      check_val("alt busy", busy, (cyc >= 1 && cyc <= 8) ? 1 : 0);
      @(posedge clk); #1;
      d_req = !((cyc + 1) == 3 || (cyc + 1) >= 7);
      i_req = !((cyc + 1) == 5 || (cyc + 1) >= 9);
    end
    $display("txn %0d: alternating I/D contention, grants D,I,D,I", txn_no);
    txn_no++;
    model_last_d = 1'b0;

    // Out-of-range fetch.
    run_group(1, 0, 16, 0, 0, 0);

    // Reset during the CMD cycle of a store to address 9.
    d_req = 1; d_we = 1; d_addr = 9; d_wdata = 32'hA5A5_0909;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("rstcmd write_ram", write_ram, 1);
    check_val("rstcmd ram_addr", ram_addr, 9);
    check_val("rstcmd ram_wdata", ram_write_data, 32'hA5A5_0909);
    @(posedge clk); #1;
    rst = 1'b0; d_req = 0;
    @(negedge clk);
    check_all_zero("post-rst");
    ref_mem[9] = 32'hA5A5_0909;
    model_last_d = 1'b0;
    $display("txn %0d: store to 9 aborted by reset in CMD", txn_no);
    txn_no++;
    @(posedge clk); #1;
    run_group(0, 1, 0, 9, 0, 0);

    // Randomized mix of single and contending requests.
    for (int n = 0; n < 40; n++) begin
      bit ion, don;
      ion = 1'($urandom_range(0, 1));
      don = 1'($urandom_range(0, 1));
      if (!ion && !don) don = 1;
      run_group(ion, don, 32'($urandom_range(0, 19)), 32'($urandom_range(0, 19)),
                1'($urandom_range(0, 1)), $urandom);
    end

    // Lone fetch port held continuously: one access per 3 cycles.
    i_req = 1; i_addr = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      check_val("solo i_done", i_done, (cyc % 3 == 2) ? 1 : 0);
      check_val("solo busy", busy, (cyc % 3 != 0) ? 1 : 0);
      check_val("solo i_rdata", i_rdata, (cyc % 3 == 2) ? ref_mem[i_addr[3:0]] : 0);
      @(posedge clk); #1;
      if (cyc % 3 == 2) begin
        if (cyc == 14) i_req = 0;
        else i_addr = i_addr + 1;
      end
    end
    $display("txn %0d: solo fetch stream addr 0..4", txn_no);
    txn_no++;
    model_last_d = 1'b0;

    for (int k = 0; k < 16; k++) check_val($sformatf("mem[%0d]", k), mem[k], ref_mem[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Arbiter and sequencer for the single-port, 16-word, 32-bit data RAM (one-cycle registered read, synchronous write).
- Shares the RAM between the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
- Drives the RAM's read_ram, write_ram, ram_addr and ram_write_data inputs, and returns ram_out to the winning requester.
- Sits between the CPU core and the RAM.

Parameters:
- DEPTH, 16, number of RAM words; valid word addresses are 0..DEPTH-1.
- AW, 32, address width of requester and RAM address ports.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_done.
- i_addr  in  AW  fetch word address.
- i_done  out  1  one-cycle pulse; fetch complete.
- i_err  out  1  valid with i_done; address was out of range.
- i_rdata  out  32  fetch data; valid only while i_done=1, else 0.
- d_req  in  1  load/store request; held high with d_we, d_addr and d_wdata stable until d_done.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data word address.
- d_wdata  in  32  store data.
- d_done  out  1  one-cycle pulse; access complete.
- d_err  out  1  valid with d_done; address was out of range.
- d_rdata  out  32  load data; valid only while d_done=1 for a load, else 0.
- read_ram  out  1  to RAM.
- write_ram  out  1  to RAM.
- ram_addr  out  AW  to RAM.
- ram_write_data  out  32  to RAM.
- ram_out  in  32  from RAM.
- busy  out  1  high in CMD or RESP state.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, last_gnt=I.
  - read_ram, write_ram, ram_addr, ram_write_data all 0.
  - All done, err and rdata outputs 0; busy=0.
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - If any eligible request is present, choose a winner and latch owner, addr, we, wdata and the range flag.
  - Go to CMD; otherwise stay in IDLE.
- CMD (exactly one cycle):
  - RAM control outputs are registered and hold the latched command for this cycle.
  - Load or fetch: read_ram=1, write_ram=0.
  - Store: write_ram=1, read_ram=0, ram_write_data=wdata.
  - ram_addr=addr.
  - Out-of-range address (addr>=DEPTH): read_ram=0, write_ram=0, ram_addr=0.
  - Always go to RESP.
- RESP (exactly one cycle):
  - Owner's done=1.
  - err=range flag.
  - Owner's rdata=ram_out for an in-range read, else 0.
  - RAM control outputs return to 0 unless a new command is issued.
  - In the same cycle, arbitrate again, excluding the owner. If the other port requests, latch it and go to CMD; else go to IDLE.
- Timing:
  - Latency: request seen in IDLE at cycle T -> done at T+2.
  - Peak throughput: one access per 2 cycles when both ports alternate.
  - A single port alone gets one access per 3 cycles, because IDLE is revisited.
- Arbitration (round-robin):
  - Only one port requesting: it wins.
  - Both requesting: the port not equal to last_gnt wins.
  - last_gnt updates on every grant.
  - After reset, a tie goes to D.
- The non-owner's done, err and rdata are always 0; done never pulses on both ports in the same cycle.
- A request dropped before done is a protocol violation; the controller still completes the latched access.
- Reset mid-operation:
  - rst in CMD: the RAM still acts on that cycle's command (a store commits).
  - At the edge, all outputs clear and state goes to IDLE; no done is issued for the aborted access.
  - rst in RESP: that cycle's done is still visible; no new grant is taken.

Test Plan:
1. After reset, d_req=1, d_we=1, d_addr=5, d_wdata=0xDEADBEEF -> write_ram=1 with ram_addr=5 in cycle T+1; d_done=1, d_err=0, d_rdata=0 at T+2.
2. Then d_req=1, d_we=0, d_addr=5 -> read_ram=1 at T+1; d_done=1 and d_rdata=0xDEADBEEF at T+2.
3. i_req and d_req both high from reset (i_addr=3, d_addr=7), each port dropping its req for one cycle after done and then re-asserting -> grant order D,I,D,I; done alternates every 2 cycles; i_rdata=RAM[3], d_rdata=RAM[7].
4. i_req=1 with i_addr=16 -> read_ram=0 and write_ram=0 throughout; i_done=1, i_err=1, i_rdata=0 at T+2; RAM contents unchanged.
5. Store to addr 9 with rst asserted during its CMD cycle -> no d_done; all outputs 0 next cycle; a subsequent load of addr 9 returns the stored data.
6. Single requester I with i_req held continuously (addr 0..4 stepped after each done) -> i_done every 3 cycles; busy low exactly one cycle between accesses.
